// File: rtl/warp_scheduler.sv
// ---------------------------------------------------------------------------
// warp_scheduler
//
// Purpose:
//   Multi-warp issue scheduler. It tracks NUM_WARPS warps of one block. In
//   each issue slot it offers one READY warp, picked by round-robin. A warp
//   whose LSU traffic is still outstanding is parked in WAIT_MEM, so the
//   other warps can issue and hide the memory latency.
//
// Optional feature:
//   WARP_SCHED_PERF_EN  when defined, issue_count and stall_cycles are real
//                       saturating counters. Otherwise both are tied to 0.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-low reset
//   start          launch pulse, honoured only in IDLE or DONE
//   warp_count     number of warps used by this block (0..NUM_WARPS)
//   issue_valid    a READY warp is offered to the front end
//   issue_warp     offered warp id (0 when nothing is offered)
//   issue_ready    front end accepts the offer this cycle
//   complete_valid an issued instruction finished
//   complete_warp  warp of the finished instruction
//   complete_kind  00 ALU/branch, 01 LDR/STR pending, 10 RET, 11 reserved
//   mem_done_valid all LSU lanes of a warp returned
//   mem_done_warp  warp whose memory traffic returned
//   ready_mask     per-warp READY flags
//   done           block finished (registered, high while in DONE)
//   issue_count    granted issues (perf build only)
//   stall_cycles   RUN cycles with no READY warp (perf build only)
// ---------------------------------------------------------------------------
module warp_scheduler #(
  parameter int NUM_WARPS     = 4,
  parameter int PERF_CNT_BITS = 16,
  localparam int WID          = $clog2(NUM_WARPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WID:0]             warp_count,
  output logic                     issue_valid,
  output logic [WID-1:0]           issue_warp,
  input  logic                     issue_ready,
  input  logic                     complete_valid,
  input  logic [WID-1:0]           complete_warp,
  input  logic [1:0]               complete_kind,
  input  logic                     mem_done_valid,
  input  logic [WID-1:0]           mem_done_warp,
  output logic [NUM_WARPS-1:0]     ready_mask,
  output logic                     done,
  output logic [PERF_CNT_BITS-1:0] issue_count,
  output logic [PERF_CNT_BITS-1:0] stall_cycles
);

  typedef enum logic [1:0] {TOP_IDLE, TOP_RUN, TOP_DONE} top_state_e;
  typedef enum logic [2:0] {W_INACTIVE, W_READY, W_ISSUED, W_WAIT_MEM, W_DONE} warp_state_e;

  top_state_e  top_q, top_d;
  warp_state_e warp_q [NUM_WARPS];
  warp_state_e warp_d [NUM_WARPS];
  logic [WID-1:0] rr_q, rr_d;

  logic [WID-1:0] sel;
  logic           any_ready;
  logic           any_active_d;
  logic           launch;
  logic           grant;
  int             idx;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      ready_mask[w] = (warp_q[w] == W_READY);
    end
  end

  // Round-robin pick: the first READY warp found by scanning upward from
  // rr_ptr and wrapping at NUM_WARPS. The scan uses integer modulo, so a
  // NUM_WARPS that is not a power of two also works.
  always_comb begin
    sel = '0;
    idx = 0;
    any_ready = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = (int'(rr_q) + i) % NUM_WARPS;
      if (!any_ready && ready_mask[idx]) begin
        any_ready = 1'b1;
        sel = WID'(idx);
      end
    end
  end

  assign issue_valid = (top_q == TOP_RUN) && any_ready;
  assign issue_warp  = issue_valid ? sel : '0;
  assign grant       = issue_valid && issue_ready;
  assign launch      = start && (top_q != TOP_RUN);
  assign done        = (top_q == TOP_DONE);

  // Next state for the block FSM, the warps and the round-robin pointer.
  // A grant, a completion and a mem_done can each change a different warp in
  // the same cycle. Each event checks the current state of its warp, so the
  // events never overlap. The move to DONE looks at the updated warp states,
  // so done rises in the cycle right after the last RET.
  always_comb begin
    top_d = top_q;
    rr_d  = rr_q;
    any_active_d = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_d[w] = warp_q[w];
    end

    if (launch) begin
      top_d = TOP_RUN;
      rr_d  = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        warp_d[w] = ((WID+1)'(w) < warp_count) ? W_READY : W_INACTIVE;
      end
    end else if (top_q == TOP_RUN) begin
      if (grant) begin
        warp_d[issue_warp] = W_ISSUED;
        rr_d = (issue_warp == WID'(NUM_WARPS-1)) ? '0 : issue_warp + WID'(1);
      end
      if (complete_valid && int'(complete_warp) < NUM_WARPS &&
          warp_q[complete_warp] == W_ISSUED) begin
        case (complete_kind)
          2'b00:   warp_d[complete_warp] = W_READY;
          2'b01:   warp_d[complete_warp] = W_WAIT_MEM;
          2'b10:   warp_d[complete_warp] = W_DONE;
          default: warp_d[complete_warp] = W_ISSUED;
        endcase
      end
      if (mem_done_valid && int'(mem_done_warp) < NUM_WARPS &&
          warp_q[mem_done_warp] == W_WAIT_MEM) begin
        warp_d[mem_done_warp] = W_READY;
      end
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (warp_d[w] == W_READY || warp_d[w] == W_ISSUED || warp_d[w] == W_WAIT_MEM) begin
          any_active_d = 1'b1;
        end
      end
      if (!any_active_d) begin
        top_d = TOP_DONE;
      end
    end
  end

  // State registers. Reset drops the block at once, and any in-flight
  // completions are lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q <= TOP_IDLE;
      rr_q  <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        warp_q[w] <= W_INACTIVE;
      end
    end else begin
      top_q <= top_d;
      rr_q  <= rr_d;
      for (int w = 0; w < NUM_WARPS; w++) begin
        warp_q[w] <= warp_d[w];
      end
    end
  end

`ifdef WARP_SCHED_PERF_EN
  logic [PERF_CNT_BITS-1:0] issue_cnt_q, stall_cnt_q;
  logic                     any_active_q;

  always_comb begin
    any_active_q = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (warp_q[w] == W_READY || warp_q[w] == W_ISSUED || warp_q[w] == W_WAIT_MEM) begin
        any_active_q = 1'b1;
      end
    end
  end

  // Saturating counters. They clear on launch, count only in RUN, and
  // therefore hold their values in DONE. A stall is a RUN cycle in which
  // launched warps are still active but none of them is READY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (launch) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (top_q == TOP_RUN) begin
      if (grant && issue_cnt_q != '1) begin
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
      if (!any_ready && any_active_q && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign issue_count  = issue_cnt_q;
  assign stall_cycles = stall_cnt_q;
`else
  assign issue_count  = '0;
  assign stall_cycles = '0;
`endif

endmodule
